// File: rtl/cdce_init_sequencer.sv
// cdce_init_sequencer: brings up the CDCE62002 through its SPI programmer, then qualifies PLL lock.
// Latency: every output is registered. Decisions take effect one cycle after the inputs are sampled.
// Backpressure: the send pulse is withheld while the programmer still reports active.
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   prog_send      - one-cycle send_data pulse to the programmer
//   prog_active    - programmer busy flag (high while the SPI stream runs)
//   pll_lock       - PLL lock status, already synchronised to clk
//   reprogram_req  - level request for a full re-init (acted on in READY/FAIL only)
//   clk_ready      - clocks qualified (state READY)
//   sys_reset      - downstream reset, released only in READY
//   init_fail      - all attempts exhausted (state FAIL, sticky)
//   lock_lost      - one-cycle pulse when lock drops while READY
//   retry_count    - attempts used beyond the first, saturating
//   state_dbg      - raw state code for debug/LEDs
module cdce_init_sequencer #(
    parameter int POWERUP_CYCLES = 1024,
    parameter int ACT_TIMEOUT    = 64,
    parameter int LOCK_STABLE    = 256,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int MAX_RETRIES    = 3,
    // A single-attempt build still needs a one-bit retry_count port.
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          prog_send,
    input  logic          prog_active,
    input  logic          pll_lock,
    input  logic          reprogram_req,
    output logic          clk_ready,
    output logic          sys_reset,
    output logic          init_fail,
    output logic          lock_lost,
    output logic [RW-1:0] retry_count,
    output logic [2:0]    state_dbg
);

    // A single shared counter serves PWRUP, WAIT_ACT and LOCK_WAIT.
    // Size it for the longest of the three intervals.
    localparam int CMAX_A = (POWERUP_CYCLES > ACT_TIMEOUT) ? POWERUP_CYCLES : ACT_TIMEOUT;
    localparam int CMAX   = (CMAX_A > LOCK_TIMEOUT) ? CMAX_A : LOCK_TIMEOUT;
    localparam int CW     = $clog2(CMAX + 1);
    localparam int SW     = $clog2(LOCK_STABLE + 1);

    localparam logic [CW-1:0] PWR_LAST  = CW'(POWERUP_CYCLES - 1);
    localparam logic [CW-1:0] ACT_LAST  = CW'(ACT_TIMEOUT - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PWRUP     = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_ACT  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_LOCK_WAIT = 3'd4,
        S_READY     = 3'd5,
        S_FAIL      = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stab;

    assign state_dbg = state;

    // clk_ready, sys_reset and init_fail are updated on the transitions into
    // and out of READY/FAIL. This keeps them registered and in step with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_PWRUP;
            cnt         <= '0;
            stab        <= '0;
            prog_send   <= 1'b0;
            clk_ready   <= 1'b0;
            sys_reset   <= 1'b1;
            init_fail   <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= '0;
        end else begin
            prog_send <= 1'b0;
            lock_lost <= 1'b0;
            case (state)
                S_PWRUP: begin
                    if (cnt == PWR_LAST) begin
                        // If the programmer is still busy from an interrupted
                        // attempt, hold here until it goes idle.
                        if (!prog_active) begin
                            state     <= S_SEND;
                            cnt       <= '0;
                            prog_send <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    state <= S_WAIT_ACT;
                    cnt   <= '0;
                end
                S_WAIT_ACT: begin
                    if (prog_active) begin
                        state <= S_WAIT_DONE;
                        cnt   <= '0;
                    end else if (cnt == ACT_LAST) begin
                        cnt <= '0;
                        if (retry_count < RETRY_MAX) begin
                            retry_count <= retry_count + 1'b1;
                            state       <= S_PWRUP;
                        end else begin
                            state     <= S_FAIL;
                            init_fail <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!prog_active) begin
                        state <= S_LOCK_WAIT;
                        cnt   <= '0;
                        stab  <= '0;
                    end
                end
                S_LOCK_WAIT: begin
                    // Qualification takes priority over a timeout in the same cycle.
                    if (pll_lock && stab == STAB_LAST) begin
                        state     <= S_READY;
                        clk_ready <= 1'b1;
                        sys_reset <= 1'b0;
                        cnt       <= '0;
                        stab      <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        cnt  <= '0;
                        stab <= '0;
                        if (retry_count < RETRY_MAX) begin
                            retry_count <= retry_count + 1'b1;
                            state       <= S_PWRUP;
                        end else begin
                            state     <= S_FAIL;
                            init_fail <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + 1'b1;
                        stab <= pll_lock ? stab + 1'b1 : '0;
                    end
                end
                S_READY: begin
                    // A lock drop only needs requalification, not reprogramming.
                    if (!pll_lock) begin
                        state     <= S_LOCK_WAIT;
                        lock_lost <= 1'b1;
                        clk_ready <= 1'b0;
                        sys_reset <= 1'b1;
                        cnt       <= '0;
                        stab      <= '0;
                    end else if (reprogram_req) begin
                        state       <= S_PWRUP;
                        clk_ready   <= 1'b0;
                        sys_reset   <= 1'b1;
                        cnt         <= '0;
                        retry_count <= '0;
                    end
                end
                S_FAIL: begin
                    if (reprogram_req) begin
                        state       <= S_PWRUP;
                        init_fail   <= 1'b0;
                        cnt         <= '0;
                        retry_count <= '0;
                    end
                end
                default: begin
                    state       <= S_PWRUP;
                    cnt         <= '0;
                    stab        <= '0;
                    clk_ready   <= 1'b0;
                    sys_reset   <= 1'b1;
                    init_fail   <= 1'b0;
                    retry_count <= '0;
                end
            endcase
        end
    end

endmodule
